// File: rtl/acc_cam.sv
// acc_cam: 16-entry account-key CAM with sequential scan, or single-cycle parallel match when ACC_CAM_PARALLEL_EN is defined.
module acc_cam #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_write_en,
  input  logic [3:0]        address_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  input  logic              search_go,
  input  logic [DATA_W-1:0] search_key,
  output logic              busy,
  output logic              search_done,
  output logic              match,
  output logic [3:0]        match_add,
  output logic [3:0]        max_add,
  output logic              cam_empty
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [16];
  logic [15:0] valid;
  logic wr, go, hit, scan_end, upd;
  logic [3:0] hit_idx;
  // Writes win over a coincident search_go; flush wins over both.
  assign wr = state == IDLE && cam_write_en && !flush;
  assign go = state == IDLE && search_go && !cam_write_en && !flush;
  assign busy = state != IDLE;
  assign cam_empty = ~|valid;
`ifdef ACC_CAM_PARALLEL_EN
  localparam state_t GO_ST = DONE;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 15; i >= 0; i--)
      if (valid[i] && mem[i] == search_key) begin
        hit = 1'b1;
        hit_idx = 4'(i);
      end
  end
  assign scan_end = 1'b1;
  assign upd = go;
`else
  localparam state_t GO_ST = SCAN;
  logic [DATA_W-1:0] key;
  logic [3:0] idx;
  assign hit = valid[idx] && mem[idx] == key;
  assign hit_idx = idx;
  assign scan_end = hit || idx == 4'd15;
  assign upd = state == SCAN && scan_end;
  always_ff @(posedge clk)
    if (go) begin
      key <= search_key;
      idx <= '0;
    end else if (state == SCAN && !scan_end) idx <= idx + 4'd1;
`endif
  always_comb
    state_nx = flush ? IDLE :
               state == IDLE ? (go ? GO_ST : IDLE) :
               state == SCAN ? (scan_end ? DONE : SCAN) : IDLE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) if (wr) mem[address_in] <= data_in;
  always_ff @(posedge clk)
    if (rst || flush) begin
      valid <= '0;
      match <= 1'b0;
      match_add <= '0;
      search_done <= 1'b0;
    end else begin
      if (wr) valid[address_in] <= 1'b1;
      search_done <= state == DONE;
      if (upd) begin
        match <= hit;
        match_add <= hit ? hit_idx : 4'd0;
      end else if (go) begin
        match <= 1'b0;
        match_add <= '0;
      end
    end
  always_comb begin
    max_add = '0;
    for (int i = 0; i < 16; i++) if (valid[i]) max_add = 4'(i);
  end
endmodule

// File: tb/tb_acc_cam.sv
// tb_acc_cam: directed scoreboard bench for acc_cam (either build of ACC_CAM_PARALLEL_EN).
module tb_acc_cam;
`ifdef ACC_CAM_PARALLEL_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int MISS = PAR ? 1 : 17;
  logic clk = 1'b0, rst = 1'b0, cam_write_en = 1'b0, flush = 1'b0, search_go = 1'b0;
  logic [3:0] address_in = '0;
  logic [63:0] data_in = '0, search_key = '0;
  logic busy, search_done, match, cam_empty;
  logic [3:0] match_add, max_add;
  int checks = 0, failures = 0;
  typedef struct { logic m; logic [3:0] a; int lat; } exp_t;
  exp_t sb[$];
  acc_cam #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst), .cam_write_en(cam_write_en), .address_in(address_in),
    .data_in(data_in), .flush(flush), .search_go(search_go), .search_key(search_key),
    .busy(busy), .search_done(search_done), .match(match), .match_add(match_add),
    .max_add(max_add), .cam_empty(cam_empty)
  );
  always #5 clk = ~clk;
  function automatic int lat_hit(input int k);
    return PAR ? 1 : 2 + k;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr_entry(input logic [3:0] a, input logic [63:0] d);
    cam_write_en = 1'b1;
    address_in = a;
    data_in = d;
    step;
    cam_write_en = 1'b0;
  endtask
  task automatic start(input logic [63:0] k, input logic m, input logic [3:0] a, input int lat);
    sb.push_back('{m, a, lat});
    search_key = k;
    search_go = 1'b1;
    step;
    search_go = 1'b0;
    chk("busy_after_go", busy, 1);
  endtask
  task automatic finish_search(input int j0);
    int j = j0;
    exp_t e;
    while (!search_done && j < 40) begin
      step;
      j++;
    end
    chk("done_seen", search_done, 1);
    e = sb.pop_front();
    chk("match", match, e.m);
    chk("match_add", match_add, e.a);
    chk("latency", j, e.lat);
  endtask
  initial begin
    int seen;
    rst = 1'b1;
    flush = 1'b1;
    search_go = 1'b1;
    step;
    step;
    rst = 1'b0;
    flush = 1'b0;
    search_go = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", search_done, 0);
    chk("rst_match", match, 0);
    chk("rst_match_add", match_add, 0);
    chk("rst_max_add", max_add, 0);
    chk("rst_empty", cam_empty, 1);
    start(64'h0, 1'b0, 4'd0, MISS);
    finish_search(0);
    chk("empty_after_search", cam_empty, 1);
    wr_entry(4'd3, 64'hA5);
    wr_entry(4'd7, 64'h5A);
    chk("max_add_7", max_add, 7);
    chk("not_empty", cam_empty, 0);
    start(64'h5A, 1'b1, 4'd7, lat_hit(7));
    finish_search(0);
    repeat (3) step;
    chk("hold_match", match, 1);
    chk("hold_match_add", match_add, 7);
    wr_entry(4'd2, 64'h11);
    wr_entry(4'd9, 64'h11);
    start(64'h11, 1'b1, 4'd2, lat_hit(2));
    finish_search(0);
    start(64'h55, 1'b0, 4'd0, MISS);
    wr_entry(4'd5, 64'h55);
    finish_search(1);
    chk("dropped_write_max", max_add, 9);
    start(64'h55, 1'b0, 4'd0, MISS);
    finish_search(0);
    cam_write_en = 1'b1;
    address_in = 4'd12;
    data_in = 64'hCC;
    search_go = 1'b1;
    search_key = 64'hCC;
    step;
    cam_write_en = 1'b0;
    search_go = 1'b0;
    chk("coincide_busy", busy, 0);
    chk("coincide_max", max_add, 12);
    seen = 0;
    repeat (20) begin
      step;
      if (search_done) seen++;
    end
    chk("coincide_no_done", seen, 0);
    start(64'hCC, 1'b1, 4'd12, lat_hit(12));
    finish_search(0);
    search_key = 64'h99;
    search_go = 1'b1;
    step;
    search_go = 1'b0;
    repeat (PAR ? 0 : 4) step;
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_empty", cam_empty, 1);
    chk("flush_max", max_add, 0);
    chk("flush_match", match, 0);
    chk("flush_match_add", match_add, 0);
    seen = 0;
    repeat (20) begin
      step;
      if (search_done) seen++;
    end
    chk("flush_no_done", seen, 0);
    wr_entry(4'd3, 64'hA5);
    wr_entry(4'd3, 64'hBB);
    chk("overwrite_max", max_add, 3);
    chk("overwrite_not_empty", cam_empty, 0);
    start(64'hA5, 1'b0, 4'd0, MISS);
    finish_search(0);
    start(64'hBB, 1'b1, 4'd3, lat_hit(3));
    finish_search(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acc_cam.md
ACC_CAM -- requirements
Module: acc_cam

Interface
REQ-001 SHALL have parameter: DATA_W, 64, width of stored account key and search key.
REQ-002 SHALL have port: clk  input  1  single rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port: cam_write_en  input  1  write data_in into entry address_in this cycle.
REQ-005 SHALL have port: address_in  input  4  write address, entries 0..15.
REQ-006 SHALL have port: data_in  input  DATA_W  key to store.
REQ-007 SHALL have port: flush  input  1  invalidate all entries.
REQ-008 SHALL have port: search_go  input  1  start a search for search_key.
REQ-009 SHALL have port: search_key  input  DATA_W  key to look up, latched at search start.
REQ-010 SHALL have port: busy  output  1  search in progress.
REQ-011 SHALL have port: search_done  output  1  one-cycle pulse, match/match_add valid.
REQ-012 SHALL have port: match  output  1  last search hit.
REQ-013 SHALL have port: match_add  output  4  entry index of last hit, 0 on miss.
REQ-014 SHALL have port: max_add  output  4  highest valid entry index, 0 when empty.
REQ-015 SHALL have port: cam_empty  output  1  no valid entries.

Function
REQ-016 SHALL hold 16 entries of DATA_W bits, each with a valid bit; all registers, no RAM macros.
REQ-017 SHALL implement states IDLE, SCAN, DONE; IDLE->SCAN on search_go, SCAN->DONE on hit or after entry 15, DONE->IDLE unconditionally.
REQ-018 SHALL, in IDLE with search_go, latch search_key, clear scan index to 0, raise busy next cycle.
REQ-019 SHALL in SCAN compare one entry per cycle, index 0 first; only valid entries can hit.
REQ-020 SHALL on first hit at index k set match=1, match_add=k; on no hit set match=0, match_add=0.
REQ-021 SHALL give latency: search_go sampled at edge N -> search_done high in cycle after edge N+2+k on hit at k, N+17 on miss.
REQ-022 SHALL keep match/match_add stable from search_done until the next search_go is accepted, then clear both to 0.
REQ-023 SHALL accept cam_write_en only in IDLE; writes while busy or in DONE are dropped, memory unchanged.
REQ-024 SHALL give write priority when cam_write_en and search_go coincide in IDLE: write performed, search_go ignored.
REQ-025 SHALL overwrite an already-valid entry in place; valid stays 1.
REQ-026 SHALL ignore search_go while busy or in DONE.
REQ-027 SHALL on flush (any state) clear all valid bits, match, match_add, go to IDLE; aborted search gives no search_done; flush beats cam_write_en in the same cycle.
REQ-028 SHALL update max_add and cam_empty the cycle after the write/flush edge; max_add = highest valid index.

Reset
REQ-029 SHALL on rst force IDLE, all valid bits 0, busy=0, search_done=0, match=0, match_add=0, max_add=0, cam_empty=1; stored data contents are don't-care.
REQ-030 SHALL give rst priority over flush, cam_write_en and search_go; rst mid-search aborts with no search_done.

Configuration
REQ-031 SHALL, with ACC_CAM_PARALLEL_EN defined, compare all 16 entries in one cycle (lowest index wins), skip SCAN: search_done at cycle after edge N+1 for hit or miss, busy high for that one DONE cycle only.
REQ-032 SHALL, without ACC_CAM_PARALLEL_EN, use the sequential scan of REQ-019..REQ-021; all other behaviour identical.

Verification
REQ-033 SHALL cover: write 0xA5 at 3, 0x5A at 7, search 0x5A -> search_done at N+9 (sequential) / N+1 (parallel), match=1, match_add=7, max_add=7.
REQ-034 SHALL cover: entries 2 and 9 both 0x11, search 0x11 -> match_add=2.
REQ-035 SHALL cover: empty CAM, search 0x0 -> match=0, match_add=0, done at N+17 (sequential); cam_empty=1.
REQ-036 SHALL cover: cam_write_en to entry 5 while busy -> entry 5 stays invalid, later search of that key misses.
REQ-037 SHALL cover: flush at scan index 4 -> no search_done, busy=0 next cycle, cam_empty=1, max_add=0.
REQ-038 SHALL cover: cam_write_en and search_go same IDLE cycle -> write lands, busy stays 0, no search_done.
